// File: rtl/mem_store_unit.sv
// mem_store_unit: memory-stage store path for the MIPS pipeline.
// The data memory is word organised with no byte enables. Word stores are written
// directly. Byte and halfword stores read the word, merge the new lane(s) and write
// it back. The pipeline is stalled until the store has committed.
//
// Optional feature: define STORE_ALIGN_CHECK_EN to trap misaligned halfword and word
// stores. A trapped store skips the memory access and pulses o_misaligned in DONE.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_exmem_mem_write        store request, held by the pipeline while o_stall=1
//   i_exmem_addr/_data       byte address and store data (rt)
//   i_ctl_datastore_size     00 word, 01 byte, 10 halfword, 11 invalid
//   i_mem_rdata              memory read data, valid the cycle after o_mem_re
//   o_mem_addr/_re/_we/_wdata  data memory port
//   o_stall                  freezes IF/ID/EX/MEM stage registers
//   o_misaligned             one-cycle misaligned-store flag
module mem_store_unit #(
    parameter int unsigned BITS_SIZE      = 32,
    parameter int unsigned HW_BITS        = 16,
    parameter int unsigned BYTE_BITS_SIZE = 8,
    parameter int unsigned MEM_ADDR_BITS  = 10
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_exmem_mem_write,
    input  logic [BITS_SIZE-1:0]     i_exmem_addr,
    input  logic [BITS_SIZE-1:0]     i_exmem_data,
    input  logic [1:0]               i_ctl_datastore_size,
    input  logic [BITS_SIZE-1:0]     i_mem_rdata,
    output logic [MEM_ADDR_BITS-1:0] o_mem_addr,
    output logic                     o_mem_re,
    output logic                     o_mem_we,
    output logic [BITS_SIZE-1:0]     o_mem_wdata,
    output logic                     o_stall,
    output logic                     o_misaligned
);

    localparam logic [1:0] SzWord = 2'b00;
    localparam logic [1:0] SzByte = 2'b01;
    localparam logic [1:0] SzHalf = 2'b10;

    typedef enum logic [2:0] {StIdle, StRead, StMerge, StWrite, StDone} state_e;

    state_e                   state_q, state_d;
    logic [MEM_ADDR_BITS+1:0] addr_q;
    logic [BITS_SIZE-1:0]     data_q;
    logic [1:0]               size_q;
    logic [BITS_SIZE-1:0]     merged_q, merged_d;
    logic                     cap_en;

    // Address bits above the memory range are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^i_exmem_addr[BITS_SIZE-1:MEM_ADDR_BITS+2];

`ifdef STORE_ALIGN_CHECK_EN
    logic mis_q, mis_in;
    assign mis_in = ((i_ctl_datastore_size == SzHalf) && i_exmem_addr[0]) ||
                    ((i_ctl_datastore_size == SzWord) && (i_exmem_addr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d     = state_q;
        cap_en      = 1'b0;
        merged_d    = merged_q;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        o_stall     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_exmem_mem_write) begin
                    o_stall = 1'b1;
                    cap_en  = 1'b1;
                    unique case (i_ctl_datastore_size)
                        SzWord:         state_d = StWrite;
                        SzByte, SzHalf: state_d = StRead;
                        default:        state_d = StDone;
                    endcase
`ifdef STORE_ALIGN_CHECK_EN
                    if (mis_in) state_d = StDone;
`endif
                end
            end
            StRead: begin
                o_mem_re = 1'b1;
                o_stall  = 1'b1;
                state_d  = StMerge;
            end
            StMerge: begin
                o_stall  = 1'b1;
                merged_d = i_mem_rdata;
                if (size_q == SzByte) begin
                    unique case (addr_q[1:0])
                        2'd0: merged_d[BYTE_BITS_SIZE-1:0] = data_q[BYTE_BITS_SIZE-1:0];
                        2'd1: merged_d[2*BYTE_BITS_SIZE-1:BYTE_BITS_SIZE] =
                                  data_q[BYTE_BITS_SIZE-1:0];
                        2'd2: merged_d[3*BYTE_BITS_SIZE-1:2*BYTE_BITS_SIZE] =
                                  data_q[BYTE_BITS_SIZE-1:0];
                        2'd3: merged_d[4*BYTE_BITS_SIZE-1:3*BYTE_BITS_SIZE] =
                                  data_q[BYTE_BITS_SIZE-1:0];
                    endcase
                end else if (addr_q[1]) begin
                    merged_d[2*HW_BITS-1:HW_BITS] = data_q[HW_BITS-1:0];
                end else begin
                    merged_d[HW_BITS-1:0] = data_q[HW_BITS-1:0];
                end
                state_d = StWrite;
            end
            StWrite: begin
                o_mem_we    = 1'b1;
                o_stall     = 1'b1;
                o_mem_wdata = (size_q == SzWord) ? data_q : merged_q;
                state_d     = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign o_mem_addr = addr_q[MEM_ADDR_BITS+1:2];

`ifdef STORE_ALIGN_CHECK_EN
    assign o_misaligned = (state_q == StDone) && mis_q;
`else
    assign o_misaligned = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= '0;
            merged_q <= '0;
`ifdef STORE_ALIGN_CHECK_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            merged_q <= merged_d;
            // Capture only on accept so later input changes are ignored.
            if (cap_en) begin
                addr_q <= i_exmem_addr[MEM_ADDR_BITS+1:0];
                data_q <= i_exmem_data;
                size_q <= i_ctl_datastore_size;
`ifdef STORE_ALIGN_CHECK_EN
                mis_q  <= mis_in;
`endif
            end
        end
    end

endmodule
